// File: rtl/rng_pkg.sv
// Shared types and helpers for the ring-oscillator entropy sequencer.
package rng_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE,
    WARMUP,
    COLLECT,
    HOLD,
    FAULT
  } rng_state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rng_rep_count.sv
// Repetition-count health test: counts consecutive equal samples and
// raises fail once the run length reaches REP_LIMIT (saturating).
module rng_rep_count
  import rng_pkg::*;
#(
  parameter int REP_LIMIT = 16,
  parameter int CNT_W     = cnt_w(REP_LIMIT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample,
  input  logic smp_bit,
  input  logic clear,
  output logic fail
);

  logic [CNT_W-1:0] rep_cnt;
  logic             last_bit;

  // Run-length counter of identical samples; restarts at 1 on a change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt  <= '0;
      last_bit <= 1'b0;
    end else if (clear) begin
      rep_cnt  <= '0;
      last_bit <= 1'b0;
    end else if (sample) begin
      last_bit <= smp_bit;
      if (rep_cnt == '0 || smp_bit != last_bit)
        rep_cnt <= CNT_W'(1);
      else if (rep_cnt != CNT_W'(REP_LIMIT))
        rep_cnt <= rep_cnt + 1'b1;
    end
  end

  assign fail = (rep_cnt == CNT_W'(REP_LIMIT));

endmodule

// File: rtl/rng_ctrl.sv
// Entropy source sequencer: oscillator gating, warm-up, decimation,
// word packing and valid/ready delivery.
// Optional repetition-count health test enabled by RNG_HEALTH_TEST_EN.
module rng_ctrl
  import rng_pkg::*;
#(
  parameter int WORD_W     = 32,
  parameter int WARMUP_CYC = 64,
  parameter int SAMPLE_DIV = 4,
  parameter int REP_LIMIT  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              clear_fail,
  output logic              osc_en,
  input  logic              rng_bit,
  output logic              rnd_valid,
  input  logic              rnd_ready,
  output logic [WORD_W-1:0] rnd_data,
  output logic              busy,
  output logic              health_fail
);

  localparam int WU_W = cnt_w(WARMUP_CYC);
  localparam int DV_W = cnt_w(SAMPLE_DIV);
  localparam int BT_W = cnt_w(WORD_W + 1);

  rng_state_e        state;
  logic [WU_W-1:0]   wu_cnt;
  logic [DV_W-1:0]   div_cnt;
  logic [BT_W-1:0]   bit_cnt;
  logic [WORD_W-1:0] shreg;
  logic              stop_pend;
  logic              sample;
  logic              word_done;
  logic              rep_fail;

  assign word_done = (bit_cnt == BT_W'(WORD_W));
  assign sample    = (state == COLLECT) && !word_done &&
                     (div_cnt == DV_W'(SAMPLE_DIV - 1));

`ifdef RNG_HEALTH_TEST_EN
  localparam int RP_W = cnt_w(REP_LIMIT + 1);

  // Run length is kept across HOLD so a stuck source is caught across word boundaries.
  logic rep_clear;
  assign rep_clear = !(state == COLLECT || state == HOLD);

  rng_rep_count #(
    .REP_LIMIT (REP_LIMIT),
    .CNT_W     (RP_W)
  ) u_rep (
    .clk     (clk),
    .rst_n   (rst_n),
    .sample  (sample),
    .smp_bit (rng_bit),
    .clear   (rep_clear),
    .fail    (rep_fail)
  );
`else
  localparam int unused_rep_limit = REP_LIMIT;
  logic unused_clear_fail;
  assign unused_clear_fail = clear_fail;
  assign rep_fail          = 1'b0;
`endif

  // Sequencer FSM with counters, shift register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wu_cnt      <= '0;
      div_cnt     <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      stop_pend   <= 1'b0;
      rnd_data    <= '0;
      rnd_valid   <= 1'b0;
      osc_en      <= 1'b0;
      busy        <= 1'b0;
      health_fail <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !stop) begin
            state  <= WARMUP;
            wu_cnt <= '0;
            osc_en <= 1'b1;
            busy   <= 1'b1;
          end
        end

        WARMUP: begin
          if (stop) begin
            state  <= IDLE;
            wu_cnt <= '0;
            osc_en <= 1'b0;
            busy   <= 1'b0;
          end else if (wu_cnt == WU_W'(WARMUP_CYC - 1)) begin
            state   <= COLLECT;
            wu_cnt  <= '0;
            div_cnt <= '0;
            bit_cnt <= '0;
          end else begin
            wu_cnt <= wu_cnt + 1'b1;
          end
        end

        COLLECT: begin
          if (stop) begin
            state   <= IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            osc_en  <= 1'b0;
            busy    <= 1'b0;
          end else if (rep_fail) begin
            state       <= FAULT;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            osc_en      <= 1'b0;
            health_fail <= 1'b1;
          end else if (word_done) begin
            // Word is published one cycle after its last sample.
            state     <= HOLD;
            rnd_data  <= shreg;
            rnd_valid <= 1'b1;
            div_cnt   <= '0;
            bit_cnt   <= '0;
          end else if (sample) begin
            div_cnt <= '0;
            shreg   <= {shreg[WORD_W-2:0], rng_bit};
            bit_cnt <= bit_cnt + 1'b1;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        HOLD: begin
          if (rnd_ready) begin
            rnd_valid <= 1'b0;
            stop_pend <= 1'b0;
            if (stop || stop_pend) begin
              state  <= IDLE;
              osc_en <= 1'b0;
              busy   <= 1'b0;
            end else begin
              state <= COLLECT;
            end
          end else if (stop) begin
            stop_pend <= 1'b1;
          end
        end

`ifdef RNG_HEALTH_TEST_EN
        FAULT: begin
          if (clear_fail) begin
            state       <= IDLE;
            health_fail <= 1'b0;
            busy        <= 1'b0;
          end
        end
`endif

        default: begin
          state     <= IDLE;
          osc_en    <= 1'b0;
          busy      <= 1'b0;
          rnd_valid <= 1'b0;
          stop_pend <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rng_ctrl.sv
// Directed self-checking bench for rng_ctrl (WORD_W=8, WARMUP_CYC=4,
// SAMPLE_DIV=2, REP_LIMIT=4). Health expectations follow RNG_HEALTH_TEST_EN.
module tb_rng_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, stop, clear_fail, rng_bit, rnd_ready;
  logic       osc_en, rnd_valid, busy, health_fail;
  logic [7:0] rnd_data;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int t0     = 0;
  int mode   = 0;   // 0: alternating per sample from t0, 1: stuck at 1
  int h, hit, bad;

  always #5 clk = ~clk;

  rng_ctrl #(
    .WORD_W     (8),
    .WARMUP_CYC (4),
    .SAMPLE_DIV (2),
    .REP_LIMIT  (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .clear_fail  (clear_fail),
    .osc_en      (osc_en),
    .rng_bit     (rng_bit),
    .rnd_valid   (rnd_valid),
    .rnd_ready   (rnd_ready),
    .rnd_data    (rnd_data),
    .busy        (busy),
    .health_fail (health_fail)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // One clock; then drive rng_bit for the next edge. In mode 0 samples land on
  // even edges after t0, giving 1,0,1,0... from the first sample at t0+6.
  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    if (mode == 0) rng_bit = ((((cyc + 1 - t0) / 2) % 2) == 1);
    else           rng_bit = 1'b1;
  endtask

  task automatic pulse_start();
    t0 = cyc + 1;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Wait for rnd_valid; returns the edge index or -1 on timeout.
  task automatic wait_valid(input int max, output int at);
    at = -1;
    for (int i = 0; i < max; i++) begin
      tick();
      if (rnd_valid) begin
        at = cyc;
        break;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; clear_fail = 1'b0;
    rng_bit = 1'b0; rnd_ready = 1'b1;
    #22;
    check("rst_osc_en", osc_en, 0);
    check("rst_valid", rnd_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_hfail", health_fail, 0);
    check("rst_data", rnd_data, 8'h00);
    rst_n = 1'b1;
    tick();

    // First word, ready high
    pulse_start();
    check("osc_en_next", osc_en, 1);
    check("busy_next", busy, 1);
    wait_valid(60, hit);
    check("lat_first", hit - t0, 21);
    check("data_first", rnd_data, 8'hAA);
    tick();
    h = cyc;
    check("valid_drop", rnd_valid, 0);
    rnd_ready = 1'b0;

    // Second word, then held un-accepted for 10 cycles
    wait_valid(60, hit);
    check("lat_second", hit - h, 17);
    check("data_second", rnd_data, 8'h55);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rnd_valid !== 1'b1 || rnd_data !== 8'h55 || osc_en !== 1'b1) bad++;
    end
    check("hold_stable", bad, 0);
    rnd_ready = 1'b1;
    tick();
    h = cyc;
    check("valid_drop2", rnd_valid, 0);
    wait_valid(60, hit);
    check("lat_third", hit - h, 17);
    check("data_third", rnd_data, 8'h55);

    // Stop after the 5th sample of a word
    tick();
    for (int i = 0; i < 10; i++) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_col_osc", osc_en, 0);
    check("stop_col_busy", busy, 0);
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (rnd_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("stop_col_quiet", bad, 0);

    // Restart with ready low, then stop during HOLD
    rnd_ready = 1'b0;
    pulse_start();
    wait_valid(60, hit);
    check("lat_restart", hit - t0, 21);
    check("data_restart", rnd_data, 8'hAA);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("hold_stop_valid", rnd_valid, 1);
    check("hold_stop_osc", osc_en, 1);
    rnd_ready = 1'b1;
    tick();
    check("hold_stop_vdrop", rnd_valid, 0);
    check("hold_stop_busy", busy, 0);
    check("hold_stop_osc0", osc_en, 0);
    check("hold_stop_data", rnd_data, 8'hAA);

    // start and stop together in IDLE
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("ss_busy", busy, 0);
    check("ss_osc", osc_en, 0);
    tick(); tick();
    check("ss_busy_late", busy, 0);

    // Stuck-at-1 source
    mode = 1;
    pulse_start();
`ifdef RNG_HEALTH_TEST_EN
    hit = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (health_fail) begin
        hit = cyc;
        break;
      end
    end
    check("hf_lat", hit - t0, 13);
    check("hf_osc", osc_en, 0);
    check("hf_valid", rnd_valid, 0);
    check("hf_busy", busy, 1);
    pulse_start();
    check("hf_start_ign", health_fail, 1);
    check("hf_start_osc", osc_en, 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("hf_stop_ign", health_fail, 1);
    clear_fail = 1'b1;
    tick();
    clear_fail = 1'b0;
    check("hf_clear", health_fail, 0);
    check("hf_clear_busy", busy, 0);
`else
    bad = 0;
    hit = -1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (health_fail !== 1'b0) bad++;
      if (rnd_valid) begin
        hit = cyc;
        break;
      end
    end
    check("nh_lat", hit - t0, 21);
    check("nh_data", rnd_data, 8'hFF);
    check("nh_hfail", bad, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
